// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and owner ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arbState_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int TMR_W = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// Bus timeout counter: cleared while idle, counts BUSY cycles without memAck.
// expired flags the last BUSY cycle allowed before the access is abandoned.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMR_W-1:0] cnt;

  // Clear has priority; the FSM leaves BUSY on expiry so the count never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / MEM stage) arbiter onto a single memory port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on a tie instead of
// fixed data-over-fetch priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instrReq,
  input  logic [ADDR_W-1:0] instrAdr,
  output logic              instrRdy,
  output logic [DATA_W-1:0] instrData,
  input  logic              dataReq,
  input  logic              dataWe,
  input  logic [ADDR_W-1:0] dataAdr,
  input  logic [DATA_W-1:0] dataWdata,
  output logic              dataRdy,
  output logic [DATA_W-1:0] dataRdata,
  output logic              memEn,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAdr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memAck,
  output logic              stallFetch,
  output logic              stallMem,
  output logic              busErr
);

  arbState_t state;
  logic      owner;
  logic      busy;
  logic      expired;
  logic      grantD;

  assign busy = (state == BUSY_I) || (state == BUSY_D);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic lastOwner;
  // On a tie, serve whoever was not served last.
  assign grantD = dataReq && (!instrReq || lastOwner == OWN_I);
`else
  assign grantD = dataReq;
`endif

  // busErr is visible during the final BUSY cycle, one cycle ahead of Rdy.
  assign busErr     = busy && !memAck && expired;
  assign stallFetch = instrReq && !instrRdy;
  assign stallMem   = dataReq && !dataRdy;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) uTimer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == IDLE),
    .en      (busy && !memAck),
    .expired (expired)
  );

  // Arbitration FSM with registered memory-side outputs and Rdy pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      memEn     <= 1'b0;
      memWe     <= 1'b0;
      memAdr    <= '0;
      memWdata  <= '0;
      instrRdy  <= 1'b0;
      dataRdy   <= 1'b0;
      instrData <= '0;
      dataRdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lastOwner <= OWN_I;
`endif
    end else begin
      instrRdy <= 1'b0;
      dataRdy  <= 1'b0;
      case (state)
        IDLE: begin
          if (grantD) begin
            state    <= BUSY_D;
            owner    <= OWN_D;
            memEn    <= 1'b1;
            memWe    <= dataWe;
            memAdr   <= dataAdr;
            memWdata <= dataWdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lastOwner <= OWN_D;
`endif
          end else if (instrReq) begin
            state    <= BUSY_I;
            owner    <= OWN_I;
            memEn    <= 1'b1;
            memWe    <= 1'b0;
            memAdr   <= instrAdr;
            memWdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lastOwner <= OWN_I;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (memAck || expired) begin
            // Timeout completes the handshake but keeps the old data word.
            if (memAck) begin
              if (owner == OWN_D) dataRdata <= memRdata;
              else                instrData <= memRdata;
            end
            state    <= RESP;
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            instrRdy <= (owner == OWN_I);
            dataRdy  <= (owner == OWN_D);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT, default 16, maximum cycles to wait for memAck (range 2..255).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instrReq  in  1  fetch request, held until instrRdy.
- instrAdr  in  ADDR_W  fetch address.
- instrRdy  out  1  one-cycle completion pulse to fetch.
- instrData  out  DATA_W  fetched word, valid with instrRdy.
- dataReq  in  1  MEM-stage request, held until dataRdy.
- dataWe  in  1  1 = store, 0 = load.
- dataAdr  in  ADDR_W  load/store address.
- dataWdata  in  DATA_W  store data.
- dataRdy  out  1  one-cycle completion pulse to MEM stage.
- dataRdata  out  DATA_W  load data, valid with dataRdy.
- memEn  out  1  memory access strobe.
- memWe  out  1  memory write enable.
- memAdr  out  ADDR_W  memory address.
- memWdata  out  DATA_W  memory write data.
- memRdata  in  DATA_W  memory read data, valid with memAck.
- memAck  in  1  memory completion.
- stallFetch  out  1  to hazard unit: instrReq && !instrRdy.
- stallMem  out  1  to hazard unit: dataReq && !dataRdy.
- busErr  out  1  one-cycle pulse on timeout.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-004 In IDLE with dataReq=1, SHALL go to BUSY_D next cycle.
REQ-005 In IDLE with only instrReq=1, SHALL go to BUSY_I next cycle.
REQ-006 In IDLE with no request, SHALL remain in IDLE.
REQ-007 On entering BUSY_x, SHALL latch the owner's address, we and wdata; the memory-side outputs SHALL present these latched values, stable until exit.
REQ-008 In BUSY_x, memEn SHALL be 1; memWe SHALL equal latched dataWe in BUSY_D and 0 in BUSY_I.
REQ-009 In BUSY_x with memAck=1, SHALL capture memRdata into the owner's data register and go to RESP.
REQ-010 In RESP, SHALL pulse exactly the owner's Rdy for one cycle, then return to IDLE.
REQ-011 Minimum latency is 3 cycles from request sampled in IDLE to Rdy, with memAck in the first BUSY cycle.
REQ-012 instrData and dataRdata SHALL hold their last captured value between transactions.
REQ-013 A timeout counter SHALL clear on BUSY entry and increment each BUSY cycle without memAck.
REQ-014 When the counter reaches TIMEOUT-1 without memAck, SHALL pulse busErr and go to RESP, leaving the owner's data register unchanged.
REQ-015 memAck outside BUSY SHALL be ignored.
REQ-016 If the owner drops its request mid-transaction, the transaction SHALL still complete and pulse Rdy.
REQ-017 stallFetch and stallMem SHALL be combinational, per the port definitions.

Reset
REQ-018 On rst=0, asynchronously: state IDLE, counter 0, all 1-bit outputs 0, data/address registers 0.
REQ-019 Reset mid-transaction SHALL abort with no Rdy pulse; a late memAck after reset release SHALL be ignored per REQ-015.

Configuration
REQ-020 Macro MEM_ARB_ROUND_ROBIN_EN:
- Defined: when both requests are pending in IDLE, grant SHALL go to the requester not served last. A 1-bit lastOwner register records the last owner and resets to instruction, so data wins the first tie.
- Undefined: fixed priority, data over instruction (REQ-004), with no lastOwner register.

Structure
REQ-021 Package mem_arb_pkg SHALL hold the FSM state enum and owner constants OWN_I/OWN_D.
REQ-022 Timeout counter SHALL be sub-module mem_arb_timer (inputs clr, en; output expired).

Verification
REQ-023 Directed scenarios:
- Single fetch to 0x40; memAck in the first BUSY cycle with memRdata=0x00500093 -> instrRdy high exactly 3 cycles after request; instrData=0x00500093; memWe=0.
- Store 0xDEADBEEF to 0x100 -> memEn=1, memWe=1, memAdr=0x100, memWdata=0xDEADBEEF until memAck; dataRdy pulses once; stallMem=1 until then.
- instrReq and dataReq raised together, fixed priority -> data served first, then fetch; stallFetch stays high throughout the data transaction.
- Same stimulus with MEM_ARB_ROUND_ROBIN_EN and both held for 4 transactions -> grant order D, I, D, I.
- memAck never asserted, TIMEOUT=16 -> busErr pulses on the 16th BUSY cycle; Rdy follows one cycle later; data register unchanged.
- rst=0 in the second BUSY cycle, then memAck after release -> memEn=0 immediately, no Rdy pulse, FSM in IDLE.
